// File: rtl/sysid_pkg.sv
`default_nettype none
// ============================================================================
// Package  : sysid_pkg
// Summary  : System-ID slave word addresses and the checker FSM state type.
// Revision : 1.0
// ============================================================================
package sysid_pkg;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RD_ID  = 2'd1,
    ST_RD_TS  = 2'd2,
    ST_REPORT = 2'd3
  } sysid_state_e;

endpackage
`default_nettype wire

// File: rtl/sysid_read_beat.sv
`default_nettype none
// ============================================================================
// Module   : sysid_read_beat
// Summary  : One Avalon read beat: strobe on the first enabled cycle, capture
//            READ_LATENCY cycles later.
// Revision : 1.0
// ============================================================================
module sysid_read_beat
  import sysid_pkg::*;
#(
  parameter int READ_LATENCY = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  output logic o_read,
  output logic o_capture
);

  localparam logic [2:0] C_LAT = 3'(READ_LATENCY);

  logic [2:0] r_cnt;

  assign o_read    = i_en && (r_cnt == 3'd0);
  assign o_capture = i_en && (r_cnt == C_LAT);

  // Counter restarts at 0 for every beat, so the strobe marks the first cycle.
  always_ff @(posedge clk) begin
    if (rst || !i_en || o_capture) begin
      r_cnt <= 3'd0;
    end else begin
      r_cnt <= r_cnt + 3'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sysid_checker.sv
`default_nettype none
// ============================================================================
// Module   : sysid_checker
// Summary  : Reads system-ID words 0 and 1 and reports a registered pass/fail.
//            Optional periodic re-check: SYSID_CHECKER_PERIODIC_EN.
// Revision : 1.0
// ============================================================================
module sysid_checker
  import sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1483316685,
  parameter int          READ_LATENCY       = 0,
  parameter bit          AUTO_START         = 1'b1
`ifdef SYSID_CHECKER_PERIODIC_EN
  ,
  parameter int          RECHECK_CYCLES     = 1024
`endif
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        match,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
`ifdef SYSID_CHECKER_PERIODIC_EN
  ,
  output logic [7:0]  fail_count
`endif
);

  sysid_state_e r_state;
  sysid_state_e w_next;

  logic        r_auto_pend;
  logic [31:0] r_id_cap;
  logic        r_done;
  logic        r_id_ok;
  logic        r_ts_ok;
  logic        r_match;
  logic [31:0] r_id_value;
  logic [31:0] r_ts_value;

  logic w_in_rd_id;
  logic w_in_rd_ts;
  logic w_read_en;
  logic w_capture;
  logic w_launch;
  logic w_report_load;
  logic w_id_hit;
  logic w_ts_hit;

  assign w_in_rd_id    = (r_state == ST_RD_ID);
  assign w_in_rd_ts    = (r_state == ST_RD_TS);
  assign w_read_en     = w_in_rd_id || w_in_rd_ts;
  assign w_report_load = w_in_rd_ts && w_capture;
  assign w_id_hit      = (r_id_cap == EXPECTED_ID);
  assign w_ts_hit      = (avm_readdata == EXPECTED_TIMESTAMP);

  sysid_read_beat #(
    .READ_LATENCY (READ_LATENCY)
  ) u_beat (
    .clk       (clock),
    .rst       (reset),
    .i_en      (w_read_en),
    .o_read    (avm_read),
    .o_capture (w_capture)
  );

`ifdef SYSID_CHECKER_PERIODIC_EN
  logic [31:0] r_recheck_cnt;
  logic        r_recheck_armed;
  logic [7:0]  r_fail_count;
  logic        w_periodic;

  assign w_periodic = r_recheck_armed && (r_recheck_cnt == 32'd0);
  assign w_launch   = start || r_auto_pend || w_periodic;
  assign fail_count = r_fail_count;

  // Countdown loaded in REPORT so the relaunch lands RECHECK_CYCLES later.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_recheck_cnt   <= 32'd0;
      r_recheck_armed <= 1'b0;
      r_fail_count    <= 8'd0;
    end else begin
      if (r_state == ST_REPORT) begin
        r_recheck_armed <= 1'b1;
        r_recheck_cnt   <= 32'(RECHECK_CYCLES - 1);
      end else if (w_periodic) begin
        r_recheck_armed <= 1'b0;
      end else if (r_recheck_armed) begin
        r_recheck_cnt <= r_recheck_cnt - 32'd1;
      end
      if (w_report_load && !(w_id_hit && w_ts_hit) && (r_fail_count != 8'hFF)) begin
        r_fail_count <= r_fail_count + 8'd1;
      end
    end
  end
`else
  assign w_launch = start || r_auto_pend;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_launch) w_next = ST_RD_ID;
      ST_RD_ID:  if (w_capture) w_next = ST_RD_TS;
      ST_RD_TS:  if (w_capture) w_next = ST_REPORT;
      ST_REPORT: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Results are loaded on the edge into REPORT so they appear with done.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_auto_pend <= AUTO_START;
      r_id_cap    <= 32'd0;
      r_done      <= 1'b0;
      r_id_ok     <= 1'b0;
      r_ts_ok     <= 1'b0;
      r_match     <= 1'b0;
      r_id_value  <= 32'd0;
      r_ts_value  <= 32'd0;
    end else begin
      r_auto_pend <= 1'b0;
      r_done      <= 1'b0;
      if (w_in_rd_id && w_capture) begin
        r_id_cap <= avm_readdata;
      end
      if (w_report_load) begin
        r_done     <= 1'b1;
        r_id_value <= r_id_cap;
        r_ts_value <= avm_readdata;
        r_id_ok    <= w_id_hit;
        r_ts_ok    <= w_ts_hit;
        r_match    <= w_id_hit && w_ts_hit;
      end
    end
  end

  assign avm_address = w_in_rd_ts ? SYSID_ADDR_TS : SYSID_ADDR_ID;
  assign busy        = (r_state != ST_IDLE);
  assign done        = r_done;
  assign id_ok       = r_id_ok;
  assign ts_ok       = r_ts_ok;
  assign match       = r_match;
  assign id_value    = r_id_value;
  assign ts_value    = r_ts_value;

endmodule
`default_nettype wire

// File: tb/tb_sysid_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_sysid_checker
// Summary  : Scoreboard bench for sysid_checker at read latencies 0 and 2.
// Revision : 1.0
// ============================================================================
module tb_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1483316685;

  typedef struct {
    int          done_cyc;
    logic [31:0] idv;
    logic [31:0] tsv;
    logic        idok;
    logic        tsok;
    logic        m;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  int   cyc   = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  logic [31:0] slv_id = EXP_ID;
  logic [31:0] slv_ts = EXP_TS;

  logic [1:0]       addr_w, read_w, busy_w, done_w, idok_w, tsok_w, match_w;
  logic [1:0][31:0] rd_w, idv_w, tsv_w;

  assign rd_w[0] = addr_w[0] ? slv_ts : slv_id;
  assign rd_w[1] = addr_w[1] ? slv_ts : slv_id;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q0[$];
  exp_t q1[$];
  int   strobes[2];

`ifdef SYSID_CHECKER_PERIODIC_EN
  logic [7:0] fc0, fc2;
`endif

  sysid_checker #(
    .READ_LATENCY (0),
    .AUTO_START   (1'b1)
`ifdef SYSID_CHECKER_PERIODIC_EN
    , .RECHECK_CYCLES (100000)
`endif
  ) dut0 (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .avm_address  (addr_w[0]),
    .avm_read     (read_w[0]),
    .avm_readdata (rd_w[0]),
    .busy         (busy_w[0]),
    .done         (done_w[0]),
    .id_ok        (idok_w[0]),
    .ts_ok        (tsok_w[0]),
    .match        (match_w[0]),
    .id_value     (idv_w[0]),
    .ts_value     (tsv_w[0])
`ifdef SYSID_CHECKER_PERIODIC_EN
    , .fail_count (fc0)
`endif
  );

  sysid_checker #(
    .READ_LATENCY (2),
    .AUTO_START   (1'b1)
`ifdef SYSID_CHECKER_PERIODIC_EN
    , .RECHECK_CYCLES (100000)
`endif
  ) dut2 (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .avm_address  (addr_w[1]),
    .avm_read     (read_w[1]),
    .avm_readdata (rd_w[1]),
    .busy         (busy_w[1]),
    .done         (done_w[1]),
    .id_ok        (idok_w[1]),
    .ts_ok        (tsok_w[1]),
    .match        (match_w[1]),
    .id_value     (idv_w[1]),
    .ts_value     (tsv_w[1])
`ifdef SYSID_CHECKER_PERIODIC_EN
    , .fail_count (fc2)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected results for a run whose launch is sampled at the end of cycle c0.
  task automatic push_run(input int c0);
    exp_t e;
    e.idv  = slv_id;
    e.tsv  = slv_ts;
    e.idok = (slv_id == EXP_ID);
    e.tsok = (slv_ts == EXP_TS);
    e.m    = e.idok && e.tsok;
    e.done_cyc = c0 + 3;
    q0.push_back(e);
    e.done_cyc = c0 + 3 + 2 * 2;
    q1.push_back(e);
  endtask

  task automatic check_done(input int k);
    exp_t e;
    int   depth;
    depth = (k == 0) ? q0.size() : q1.size();
    if (depth == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL d%0d unexpected_done: done=1 at cycle %0d, required no pending run", k, cyc);
    end else begin
      if (k == 0) e = q0.pop_front();
      else        e = q1.pop_front();
      chk($sformatf("d%0d done_cycle", k), 32'(cyc), 32'(e.done_cyc));
      chk($sformatf("d%0d id_value", k), idv_w[k], e.idv);
      chk($sformatf("d%0d ts_value", k), tsv_w[k], e.tsv);
      chk($sformatf("d%0d ok_bits", k), 32'({idok_w[k], tsok_w[k], match_w[k]}),
          32'({e.idok, e.tsok, e.m}));
      chk($sformatf("d%0d strobes", k), 32'(strobes[k]), 32'd2);
      chk($sformatf("d%0d busy_at_done", k), 32'(busy_w[k]), 32'd1);
    end
    strobes[k] = 0;
  endtask

  always @(negedge clock) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        strobes[k] = 0;
      end else begin
        if (read_w[k]) strobes[k]++;
        if (done_w[k]) check_done(k);
      end
    end
  end

  task automatic chk_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s d%0d ctrl", tag, k),
          32'({busy_w[k], done_w[k], read_w[k], addr_w[k], idok_w[k], tsok_w[k], match_w[k]}), 32'd0);
      chk($sformatf("%s d%0d id_value", tag, k), idv_w[k], 32'd0);
      chk($sformatf("%s d%0d ts_value", tag, k), tsv_w[k], 32'd0);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start(output int c0);
    start = 1'b1;
    c0    = cyc;
    next_cycle();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || busy_w != 2'b00) && n < max_cyc) begin
      next_cycle();
      n++;
    end
    n_cmp++;
    if (n >= max_cyc) begin
      n_bad++;
      $display("FAIL wait_idle: timeout after %0d cycles, pending %0d/%0d", n, q0.size(), q1.size());
      q0.delete();
      q1.delete();
    end
    repeat (4) next_cycle();
  endtask

`ifdef SYSID_CHECKER_PERIODIC_EN
  logic       rst_p = 1'b1;
  logic       start_p = 1'b0;
  logic       addr_p, read_p, busy_p, done_p, idok_p, tsok_p, match_p;
  logic [31:0] rd_p, idv_p, tsv_p;
  logic [7:0] fc_p;
  int         np = 0;
  int         last_p = 0;
  bit         p_done = 1'b0;

  assign rd_p = addr_p ? EXP_TS : 32'h0000_0001;

  sysid_checker #(
    .READ_LATENCY   (0),
    .AUTO_START     (1'b1),
    .RECHECK_CYCLES (16)
  ) dutp (
    .clock        (clock),
    .reset        (rst_p),
    .start        (start_p),
    .avm_address  (addr_p),
    .avm_read     (read_p),
    .avm_readdata (rd_p),
    .busy         (busy_p),
    .done         (done_p),
    .id_ok        (idok_p),
    .ts_ok        (tsok_p),
    .match        (match_p),
    .id_value     (idv_p),
    .ts_value     (tsv_p),
    .fail_count   (fc_p)
  );

  // Each relaunch follows REPORT by 16 cycles, then takes 3 more to report.
  always @(negedge clock) begin
    if (!rst_p && done_p && !p_done) begin
      np++;
      if (np > 1) chk("p spacing", 32'(cyc - last_p), 32'd19);
      chk("p fail_count", 32'(fc_p), 32'((np > 255) ? 255 : np));
      chk("p match", 32'({idok_p, tsok_p, match_p}), 32'b010);
      last_p = cyc;
      if (np == 260) p_done = 1'b1;
    end
  end
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int c0;
    strobes[0] = 0;
    strobes[1] = 0;

    // Reset state, then the AUTO_START run after release.
    repeat (3) next_cycle();
    chk_zero("reset");
    reset = 1'b0;
`ifdef SYSID_CHECKER_PERIODIC_EN
    rst_p = 1'b0;
`endif
    push_run(cyc);
    wait_idle(40);

    // Explicit start; extra starts while busy and in REPORT are ignored.
    pulse_start(c0);
    push_run(c0);
    next_cycle();
    start = 1'b1;
    next_cycle();
    next_cycle();
    start = 1'b0;
    wait_idle(40);

    // Bad ID word.
    slv_id = 32'h0000_0001;
    pulse_start(c0);
    push_run(c0);
    wait_idle(40);

    // Bad timestamp word; results must then hold between runs.
    slv_id = EXP_ID;
    slv_ts = 32'h1234_5678;
    pulse_start(c0);
    push_run(c0);
    wait_idle(40);
    repeat (5) next_cycle();
    chk("hold d0 id_value", idv_w[0], 32'd0);
    chk("hold d1 ts_value", tsv_w[1], 32'h1234_5678);
    chk("hold d0 ok_bits", 32'({idok_w[0], tsok_w[0], match_w[0]}), 32'b100);

    // Reset during the timestamp capture cycle of the latency-0 instance.
    slv_ts = EXP_TS;
    pulse_start(c0);
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    chk_zero("abort");
    push_run(c0 + 3);
    wait_idle(40);

`ifdef SYSID_CHECKER_PERIODIC_EN
    begin
      int n;
      n = 0;
      while (!p_done && n < 8000) begin
        next_cycle();
        n++;
      end
      n_cmp++;
      if (!p_done) begin
        n_bad++;
        $display("FAIL periodic: only %0d runs seen, required 260", np);
      end
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
